dmem_ctrl: RTL and testbench

- Parametrised data-memory block for the MCU. Generalises the fixed 256x32 word memory.
- Adds configurable width and depth, byte-lane write strobes and byte addressing.
- Adds a valid/ready request/response handshake with one-cycle read latency, out-of-range/misalignment error reporting, and a post-reset sequential clear engine.
- Sits between the core load/store unit and the on-chip RAM array.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_ram_core.sv | 37 +++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: width helper and FSM encoding.
package dmem_pkg;

  // Ceiling log2; returns 0 for an argument of 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1
  } state_e;

endpackage

// File: rtl/dmem_ram_core.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_ram_core
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                                            clk_i,
  input  logic                                            en_i,
  input  logic [DATA_W/8-1:0]                             we_i,
  input  logic [((clog2(DEPTH) > 0) ? clog2(DEPTH) : 1)-1:0] addr_i,
  input  logic [DATA_W-1:0]                               wdata_i,
  output logic [DATA_W-1:0]                               rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write-first per lane: the read register sees the merged word of the same access.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int k = 0; k < BE_W; k++) begin
        if (we_i[k]) begin
          mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
          rdata_q[8*k +: 8]     <= wdata_i[8*k +: 8];
        end else begin
          rdata_q[8*k +: 8]     <= mem[addr_i][8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response front end, range/alignment
// checking and a post-reset clear engine in front of dmem_ram_core.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB   = clog2(BE_W);
  localparam int IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'(BE_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam state_e            RST_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0]  idx_full;
  logic               req_err;
  logic               accept;

  logic               ram_en;
  logic [BE_W-1:0]    ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  // Range check uses the full-width index so high address bits never alias.
  assign idx_full  = req_addr >> LSB;
  assign req_err   = (idx_full >= DEPTH_A) || ((req_addr & LSB_MASK) != '0);
  assign req_ready = !rst && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    ram_en      = 1'b0;
    ram_we      = '0;
    ram_addr    = idx_full[IDX_W-1:0];
    ram_wdata   = req_wdata;
    case (state_q)
      INIT: begin
        // RAM is left alone while rst is held; clearing starts on release.
        ram_en    = !rst;
        ram_we    = {BE_W{!rst}};
        ram_addr  = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = req_err;
          ram_en      = !req_err;
          ram_we      = (req_we && !req_err) ? req_be : '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  dmem_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The array's read register only updates on accepted in-range requests, so it holds the response.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? ram_rdata : '0;
  assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: A = 16 words with clear engine, B = 256 words without.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, init_busy_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, init_busy_b;
  logic [31:0] rsp_rdata_b;

  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic b_busy_seen = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];
  logic        err_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (init_busy_b === 1'b1) b_busy_seen <= 1'b1;
  end

  dmem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .INIT_ON_RESET(1)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .req_valid (req_valid & ~sel),
    .req_ready (req_ready_a),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready | sel),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a),
    .init_busy (init_busy_a)
  );

  dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .INIT_ON_RESET(0)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .req_valid (req_valid & sel),
    .req_ready (req_ready_b),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready | ~sel),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b),
    .init_busy (init_busy_b)
  );

  assign req_ready_s = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_s   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata_s = sel ? rsp_rdata_b : rsp_rdata_a;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_d, input logic exp_e);
    int w;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    #1;
    w = 0;
    while (!req_ready_s && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check({tag, ":req_ready"}, 32'(req_ready_s), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({tag, ":rsp_valid"}, 32'(rsp_valid_s), 32'd1);
    check({tag, ":rdata"}, rsp_rdata_s, exp_d);
    check({tag, ":err"}, 32'(rsp_err_s), 32'(exp_e));
  endtask

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_d = exp_d; v.exp_e = exp_e;
    vq.push_back(v);
  endtask

  task automatic check_rsp(input string tag, input int i);
    logic [31:0] ed;
    logic        ee;
    ed = exp_q.pop_front();
    ee = err_q.pop_front();
    check($sformatf("%s[%0d]:rsp_valid", tag, i), 32'(rsp_valid_s), 32'd1);
    check($sformatf("%s[%0d]:rdata", tag, i), rsp_rdata_s, ed);
    check($sformatf("%s[%0d]:err", tag, i), 32'(rsp_err_s), 32'(ee));
  endtask

  // One request per cycle with rsp_ready held high; each response checked the next cycle.
  task automatic run_stream(input string tag);
    int n;
    n = vq.size();
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1; req_we = vq[i].we; req_addr = vq[i].addr;
      req_wdata = vq[i].wdata; req_be = vq[i].be;
      #1;
      check($sformatf("%s[%0d]:req_ready", tag, i), 32'(req_ready_s), 32'd1);
      if (i > 0) check_rsp(tag, i - 1);
      exp_q.push_back(vq[i].exp_d);
      err_q.push_back(vq[i].exp_e);
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    check_rsp(tag, n - 1);
    @(negedge clk); #1;
    check({tag, ":drain"}, 32'(rsp_valid_s), 32'd0);
    vq.delete();
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (init_busy_a && !req_ready_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, ":busy_cycles"}, 32'(n), 32'd16);
    check({tag, ":ready_after"}, 32'(req_ready_a), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a:req_ready", 32'(req_ready_a), 32'd0);
    check("rst_a:rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_a:rsp_rdata", rsp_rdata_a, 32'd0);
    check("rst_a:rsp_err", 32'(rsp_err_a), 32'd0);
    check("rst_a:init_busy", 32'(init_busy_a), 32'd1);
    check("rst_b:req_ready", 32'(req_ready_b), 32'd0);
    check("rst_b:init_busy", 32'(init_busy_b), 32'd0);

    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("b:ready_first_cycle", 32'(req_ready_b), 32'd1);
    count_busy("clear");

    do_req("rd_3c", 1'b0, 32'h3C, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    do_req("wr_full", 1'b1, 32'h08, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b0);
    do_req("wr_be5", 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0);
    do_req("rd_08", 1'b0, 32'h08, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    do_req("wr_be0", 1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0000, 32'h11BB_33DD, 1'b0);

    add_vec(1'b1, 32'h00, 32'hA0A0_A0A0, 4'hF, 32'hA0A0_A0A0, 1'b0);
    add_vec(1'b1, 32'h04, 32'hB1B1_B1B1, 4'hF, 32'hB1B1_B1B1, 1'b0);
    add_vec(1'b0, 32'h00, 32'h0,         4'h0, 32'hA0A0_A0A0, 1'b0);
    add_vec(1'b1, 32'h0C, 32'h1234_5678, 4'hF, 32'h1234_5678, 1'b0);
    add_vec(1'b0, 32'h0C, 32'h0,         4'h0, 32'h1234_5678, 1'b0);
    add_vec(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h8, 32'hFF34_5678, 1'b0);
    add_vec(1'b0, 32'h0C, 32'h0,         4'h0, 32'hFF34_5678, 1'b0);
    add_vec(1'b0, 32'h40, 32'h0,         4'h0, 32'h0,         1'b1);
    add_vec(1'b0, 32'h06, 32'h0,         4'h0, 32'h0,         1'b1);
    add_vec(1'b1, 32'h3C, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0);
    add_vec(1'b0, 32'h3C, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    add_vec(1'b0, 32'h08, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
    run_stream("stream_a");

    // Three reads with the second response stalled for two cycles.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00; rsp_ready = 1'b1;
    #1;
    check("stall:rdy0", 32'(req_ready_a), 32'd1);
    @(negedge clk);
    req_addr = 32'h04; #1;
    check("stall:rsp0", rsp_rdata_a, 32'hA0A0_A0A0);
    check("stall:rdy1", 32'(req_ready_a), 32'd1);
    @(negedge clk);
    req_addr = 32'h08; rsp_ready = 1'b0; #1;
    check("stall:rsp1_valid", 32'(rsp_valid_a), 32'd1);
    check("stall:rsp1", rsp_rdata_a, 32'hB1B1_B1B1);
    check("stall:rdy_low1", 32'(req_ready_a), 32'd0);
    @(negedge clk); #1;
    check("stall:rsp1_held", rsp_rdata_a, 32'hB1B1_B1B1);
    check("stall:rsp1_vheld", 32'(rsp_valid_a), 32'd1);
    check("stall:rdy_low2", 32'(req_ready_a), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1; #1;
    check("stall:rsp1_held2", rsp_rdata_a, 32'hB1B1_B1B1);
    check("stall:rdy_back", 32'(req_ready_a), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; #1;
    check("stall:rsp2_valid", 32'(rsp_valid_a), 32'd1);
    check("stall:rsp2", rsp_rdata_a, 32'h11BB_33DD);
    @(negedge clk); #1;
    check("stall:drain", 32'(rsp_valid_a), 32'd0);

    // Error and boundary cases on the 256-word instance.
    sel = 1'b1;
    add_vec(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1'b0);
    add_vec(1'b0, 32'h0000_0402, 32'h0,         4'h0, 32'h0,         1'b1);
    add_vec(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1);
    add_vec(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    add_vec(1'b1, 32'h0000_03FC, 32'h55AA_55AA, 4'hF, 32'h55AA_55AA, 1'b0);
    add_vec(1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0);
    add_vec(1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 32'h0,         1'b1);
    add_vec(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    run_stream("stream_b");
    sel = 1'b0;

    // Pending response dropped by reset, then reset pulsed mid-clear.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0C; #1;
    @(negedge clk);
    req_valid = 1'b0; #1;
    check("pend:valid", 32'(rsp_valid_a), 32'd1);
    check("pend:rdata", rsp_rdata_a, 32'hFF34_5678);
    rst_a = 1'b1; #1;
    check("pend:dropped", 32'(rsp_valid_a), 32'd0);
    check("pend:rdata_rst", rsp_rdata_a, 32'd0);
    check("pend:ready_rst", 32'(req_ready_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rsp_ready = 1'b1; #1;
    repeat (7) @(negedge clk);
    rst_a = 1'b1; #1;
    check("midinit:busy_in_rst", 32'(init_busy_a), 32'd1);
    @(negedge clk);
    rst_a = 1'b0; #1;
    count_busy("midinit");
    for (int i = 0; i < 16; i++) add_vec(1'b0, 32'(i * 4), 32'h0, 4'h0, 32'h0, 1'b0);
    run_stream("cleared");

    check("b:init_busy_never", 32'(b_busy_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
